bram_fill_writer: RTL and testbench



---
 rtl/msb_pkg.sv | 28 ++
 rtl/bram_fill_writer_if.sv | 41 ++++
 rtl/bram_fill_parity.sv | 23 ++
 rtl/bram_fill_writer.sv | 135 +++++++++++++
 tb/tb_bram_fill_writer.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/msb_pkg.sv
// Shared constants and types for the multi-stream buffer L1 fill path.
// BEATS is derived from the BRAM geometry and must be a power of two of at least 2.
package msb_pkg;

  localparam int DATA_WIDTH      = 64;
  localparam int WAYS            = 8;
  localparam int RAM_DEPTH       = 512;
  localparam int l1_nstrms       = 16;
  localparam int l1_ncl          = 16;

  localparam int ADDR_WIDTH      = $clog2(RAM_DEPTH);
  localparam int l1_nstrms_width = $clog2(l1_nstrms);
  localparam int l1_ncl_width    = $clog2(l1_ncl);
  localparam int BEATS           = RAM_DEPTH / (l1_nstrms * l1_ncl);
  localparam int BEAT_IDX_WIDTH  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BEAT_WIDTH      = WAYS * DATA_WIDTH;

  // Bit positions within the sticky o_err vector.
  localparam int ERR_LAST = 0;
  localparam int ERR_ADDR = 1;
  localparam int ERR_PAR  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

endpackage

// File: rtl/bram_fill_writer_if.sv
// Fill-beat, BRAM write and line-complete signals of one write channel.
// With BRAM_FILL_PARITY_EN defined the bundle also carries one even-parity bit per element.
interface bram_fill_writer_if;
  import msb_pkg::*;

  logic                       i_v;
  logic                       i_r;
  logic [l1_nstrms_width-1:0] i_st;
  logic [l1_ncl_width-1:0]    i_cl;
  logic [BEAT_WIDTH-1:0]      i_d;
  logic                       i_last;
  logic                       i_flush;
`ifdef BRAM_FILL_PARITY_EN
  logic [WAYS-1:0]            i_par;
`endif
  logic                       o_we;
  logic [ADDR_WIDTH-1:0]      o_wa;
  logic [BEAT_WIDTH-1:0]      o_wd;
  logic                       o_done_v;
  logic                       o_done_r;
  logic [l1_nstrms_width-1:0] o_done_st;
  logic [l1_ncl_width-1:0]    o_done_cl;
  logic [2:0]                 o_err;

  modport master (
`ifdef BRAM_FILL_PARITY_EN
    output i_par,
`endif
    output i_v, i_st, i_cl, i_d, i_last, i_flush, o_done_r,
    input  i_r, o_we, o_wa, o_wd, o_done_v, o_done_st, o_done_cl, o_err
  );

  modport slave (
`ifdef BRAM_FILL_PARITY_EN
    input  i_par,
`endif
    input  i_v, i_st, i_cl, i_d, i_last, i_flush, o_done_r,
    output i_r, o_we, o_wa, o_wd, o_done_v, o_done_st, o_done_cl, o_err
  );

endinterface

// File: rtl/bram_fill_parity.sv
// Combinational even-parity check of each DATA_WIDTH element of a fill beat.
// Only present when BRAM_FILL_PARITY_EN is defined.
`ifdef BRAM_FILL_PARITY_EN
module bram_fill_parity
  import msb_pkg::*;
(
  input  logic [BEAT_WIDTH-1:0] d,
  input  logic [WAYS-1:0]       par,
  output logic                  err
);

  logic [WAYS-1:0] bad;

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      bad[w] = (^d[w*DATA_WIDTH +: DATA_WIDTH]) ^ par[w];
    end
  end

  assign err = |bad;

endmodule
`endif

// File: rtl/bram_fill_writer.sv
// Per-channel L1 fill writer: turns L2 fill beats into BRAM writes and posts line-complete notifications.
// Define BRAM_FILL_PARITY_EN to check per-element parity and suppress done for corrupted lines.
module bram_fill_writer
  import msb_pkg::*;
(
  input logic               clk1x,
  input logic               reset_n,
  bram_fill_writer_if.slave bus
);

  if (BEATS < 2 || (BEATS & (BEATS - 1)) != 0) begin : g_beats_check
    $error("bram_fill_writer: BEATS must be a power of two and at least 2");
  end

  fill_state_e                state_q, state_d;
  logic [BEAT_IDX_WIDTH-1:0]  beat_q, beat_d;
  logic [l1_nstrms_width-1:0] st_q, st_d, cur_st, pend_st_q;
  logic [l1_ncl_width-1:0]    cl_q, cl_d, cur_cl, pend_cl_q;
  logic                       line_perr_q, line_perr_d;
  logic                       accept, beat_perr, we_d, complete_d, pend_v_q;
  logic [ADDR_WIDTH-1:0]      wa_d;
  logic [2:0]                 err_set;

  // The only backpressure is a stalled done notification; held low while in reset.
  assign bus.i_r = reset_n & ~(bus.o_done_v & ~bus.o_done_r);
  assign accept  = bus.i_v & bus.i_r;

`ifdef BRAM_FILL_PARITY_EN
  bram_fill_parity u_parity (
    .d   (bus.i_d),
    .par (bus.i_par),
    .err (beat_perr)
  );
`else
  assign beat_perr = 1'b0;
`endif

  // The first beat takes its line address from the inputs; later beats use the latched one.
  assign cur_st = (state_q == IDLE) ? bus.i_st : st_q;
  assign cur_cl = (state_q == IDLE) ? bus.i_cl : cl_q;
  assign wa_d   = {cur_st, cur_cl, beat_q};

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can infer a latch.
    state_d     = state_q;
    beat_d      = beat_q;
    st_d        = st_q;
    cl_d        = cl_q;
    line_perr_d = line_perr_q;
    we_d        = 1'b0;
    complete_d  = 1'b0;
    err_set     = '0;

    if (bus.i_flush) begin
      state_d     = IDLE;
      beat_d      = '0;
      line_perr_d = 1'b0;
    end else if (accept) begin
      we_d             = 1'b1;
      err_set[ERR_PAR] = beat_perr;
      if (state_q == FILL && (bus.i_st != st_q || bus.i_cl != cl_q)) begin
        err_set[ERR_ADDR] = 1'b1;
      end

      if (beat_q == BEAT_IDX_WIDTH'(BEATS - 1)) begin
        state_d     = IDLE;
        beat_d      = '0;
        line_perr_d = 1'b0;
        if (bus.i_last) complete_d = ~(line_perr_q | beat_perr);
        else            err_set[ERR_LAST] = 1'b1;
      end else if (bus.i_last) begin
        state_d           = IDLE;
        beat_d            = '0;
        line_perr_d       = 1'b0;
        err_set[ERR_LAST] = 1'b1;
      end else begin
        state_d     = FILL;
        beat_d      = beat_q + 1'b1;
        st_d        = cur_st;
        cl_d        = cur_cl;
        line_perr_d = line_perr_q | beat_perr;
      end
    end
  end

  always_ff @(posedge clk1x or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      beat_q        <= '0;
      st_q          <= '0;
      cl_q          <= '0;
      line_perr_q   <= 1'b0;
      pend_v_q      <= 1'b0;
      pend_st_q     <= '0;
      pend_cl_q     <= '0;
      // NOTE: the write datapath is reset too, because every output must read 0 during reset.
      bus.o_we      <= 1'b0;
      bus.o_wa      <= '0;
      bus.o_wd      <= '0;
      bus.o_done_v  <= 1'b0;
      bus.o_done_st <= '0;
      bus.o_done_cl <= '0;
      bus.o_err     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      beat_q      <= beat_d;
      st_q        <= st_d;
      cl_q        <= cl_d;
      line_perr_q <= line_perr_d;

      bus.o_we <= we_d;
      if (we_d) begin
        bus.o_wa <= wa_d;
        bus.o_wd <= bus.i_d;
      end
      bus.o_err <= bus.o_err | err_set;

      // Done is staged one cycle behind the final write so readers never see stale data.
      pend_v_q <= complete_d;
      if (complete_d) begin
        pend_st_q <= cur_st;
        pend_cl_q <= cur_cl;
      end
      if (pend_v_q) begin
        bus.o_done_v  <= 1'b1;
        bus.o_done_st <= pend_st_q;
        bus.o_done_cl <= pend_cl_q;
      end else if (bus.o_done_r) begin
        bus.o_done_v  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bram_fill_writer.sv
// Scoreboard bench for bram_fill_writer: directed line scenarios followed by random fill traffic.
// Build with BRAM_FILL_PARITY_EN defined to also exercise the parity path.
module tb_bram_fill_writer;
  import msb_pkg::*;

  localparam int BW = BEAT_WIDTH;

  typedef struct { int cyc; int addr; logic [BW-1:0] data; } wr_t;
  typedef struct { int cyc; int st; int cl; } dn_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bram_fill_writer_if bus();

  bram_fill_writer dut (
    .clk1x   (clk),
    .reset_n (rst_n),
    .bus     (bus.slave)
  );

  int cyc      = 0;
  int n_checks = 0;
  int n_errors = 0;

  wr_t wq[$];
  dn_t dq[$];
  wr_t w_e;
  logic [2:0] err_at [int];
  logic [2:0] exp_err = 3'b000;

  // Reference model: position within the current line plus the line's identity.
  int   m_pos = 0;
  int   m_st  = 0;
  int   m_cl  = 0;
  bit   m_bad = 1'b0;
  logic [2:0] m_err = 3'b000;

  bit mon_en    = 1'b0;
  bit done_seen = 1'b0;
  int held_st, held_cl;
  bit acc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [BW-1:0] rand_beat();
    logic [BW-1:0] d;
    for (int i = 0; i < BW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [WAYS-1:0] even_par(input logic [BW-1:0] d);
    logic [WAYS-1:0] p;
    for (int w = 0; w < WAYS; w++) p[w] = ^d[w*DATA_WIDTH +: DATA_WIDTH];
    return p;
  endfunction

  // Apply the line rules to one accepted beat; k is the cycle in which its write appears.
  task automatic model_beat(input int st, input int cl, input logic [BW-1:0] d,
                            input bit last, input bit par_ok, input int k);
    int ast, acl;
    logic [2:0] e;
    e = 3'b000;
    if (m_pos == 0) begin
      ast = st; acl = cl; m_bad = 1'b0;
    end else begin
      ast = m_st; acl = m_cl;
      if (st != m_st || cl != m_cl) e[1] = 1'b1;
    end
    wq.push_back('{k, (ast * l1_ncl + acl) * BEATS + m_pos, d});
    if (!par_ok) begin
      e[2] = 1'b1; m_bad = 1'b1;
    end
    if (last && m_pos == BEATS - 1) begin
      if (!m_bad) dq.push_back('{k + 1, ast, acl});
      m_pos = 0;
    end else if (last || m_pos == BEATS - 1) begin
      e[0] = 1'b1; m_pos = 0;
    end else begin
      m_st = ast; m_cl = acl; m_pos++;
    end
    m_err = m_err | e;
    err_at[k] = m_err;
  endtask

  task automatic drive(input bit v, input int st, input int cl, input bit last,
                       input bit flush, input bit flip, input bit dr, output bit accepted);
    logic [BW-1:0] d;
    bit ok;
    @(negedge clk);
    #1;
    d = rand_beat();
    bus.i_v      = v;
    bus.i_st     = l1_nstrms_width'(st);
    bus.i_cl     = l1_ncl_width'(cl);
    bus.i_d      = d;
    bus.i_last   = last;
    bus.i_flush  = flush;
    bus.o_done_r = dr;
    ok = 1'b1;
`ifdef BRAM_FILL_PARITY_EN
    begin
      logic [WAYS-1:0] fm;
      fm = '0;
      if (flip) fm[$urandom_range(WAYS - 1)] = 1'b1;
      bus.i_par = even_par(d) ^ fm;
      ok = !flip;
    end
`endif
    #1;
    accepted = v && bus.i_r;
    if (flush) m_pos = 0;
    else if (accepted) model_beat(st, cl, d, last, ok, cyc + 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
  endtask

  // Monitor: samples mid-cycle after the driver has settled o_done_r.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (mon_en && rst_n) begin
        check("i_r", bus.i_r, !(bus.o_done_v && !bus.o_done_r));
        if (err_at.exists(cyc)) exp_err = err_at[cyc];
        check("o_err", bus.o_err, exp_err);

        if (bus.o_we) begin
          if (wq.size() == 0) check("unexpected_we", bus.o_we, 1'b0);
          else begin
            w_e = wq.pop_front();
            check("we_cycle", cyc, w_e.cyc);
            check("o_wa", bus.o_wa, w_e.addr);
            check("o_wd", bus.o_wd, w_e.data);
          end
        end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
          check("missing_we", bus.o_we, 1'b1);
          void'(wq.pop_front());
        end

        if (bus.o_done_v) begin
          if (!done_seen) begin
            if (dq.size() == 0) check("unexpected_done", bus.o_done_v, 1'b0);
            else begin
              check("done_cycle", cyc, dq[0].cyc);
              check("done_st", bus.o_done_st, dq[0].st);
              check("done_cl", bus.o_done_cl, dq[0].cl);
            end
            held_st   = bus.o_done_st;
            held_cl   = bus.o_done_cl;
            done_seen = 1'b1;
          end else begin
            check("done_st_stable", bus.o_done_st, held_st);
            check("done_cl_stable", bus.o_done_cl, held_cl);
          end
          if (bus.o_done_r) begin
            if (dq.size() > 0) void'(dq.pop_front());
            done_seen = 1'b0;
          end
        end else if (dq.size() > 0 && dq[0].cyc <= cyc) begin
          check("missing_done", bus.o_done_v, 1'b1);
          void'(dq.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bus.i_v = 1'b0; bus.i_st = '0; bus.i_cl = '0; bus.i_d = '0;
    bus.i_last = 1'b0; bus.i_flush = 1'b0; bus.o_done_r = 1'b1;
`ifdef BRAM_FILL_PARITY_EN
    bus.i_par = '0;
`endif

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_o_we", bus.o_we, 1'b0);
    check("rst_o_wa", bus.o_wa, 0);
    check("rst_o_wd", bus.o_wd, 0);
    check("rst_o_done_v", bus.o_done_v, 1'b0);
    check("rst_o_done_st", bus.o_done_st, 0);
    check("rst_o_done_cl", bus.o_done_cl, 0);
    check("rst_o_err", bus.o_err, 0);
    check("rst_i_r", bus.i_r, 1'b0);
    #1 rst_n = 1'b1;
    #1 check("i_r_after_reset", bus.i_r, 1'b1);
    mon_en = 1'b1;

    // Back-to-back two-beat line.
    drive(1'b1, 3, 5, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    drive(1'b1, 3, 5, 1'b1, 1'b0, 1'b0, 1'b1, acc);
    idle(3);

    // Stalled done: one more beat slips in, then input is blocked until o_done_r rises.
    drive(1'b1, 7, 2, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    drive(1'b1, 7, 2, 1'b1, 1'b0, 1'b0, 1'b1, acc);
    drive(1'b1, 7, 3, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    check("accept_before_done", acc, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 7, 3, 1'b1, 1'b0, 1'b0, 1'b0, acc);
      check("blocked_while_done_held", acc, 1'b0);
    end
    drive(1'b1, 7, 3, 1'b1, 1'b0, 1'b0, 1'b1, acc);
    check("accept_on_done_r", acc, 1'b1);
    idle(4);

    // Early i_last on beat 0.
    drive(1'b1, 4, 4, 1'b1, 1'b0, 1'b0, 1'b1, acc);
    idle(3);
    check("err_early_last", bus.o_err, 3'b001);

    // Address change mid-line: write stays on the latched line.
    drive(1'b1, 3, 5, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    drive(1'b1, 3, 6, 1'b1, 1'b0, 1'b0, 1'b1, acc);
    idle(4);

    // Flush together with the final beat, then a clean line at address 0.
    drive(1'b1, 1, 1, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    drive(1'b1, 1, 1, 1'b1, 1'b1, 1'b0, 1'b1, acc);
    drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    drive(1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, acc);
    idle(4);

    // Final beat without i_last wraps back to IDLE.
    drive(1'b1, 2, 9, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    drive(1'b1, 2, 9, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    idle(3);

`ifdef BRAM_FILL_PARITY_EN
    // Corrupt parity on beat 0: both beats written, no done.
    drive(1'b1, 5, 5, 1'b0, 1'b0, 1'b1, 1'b1, acc);
    drive(1'b1, 5, 5, 1'b1, 1'b0, 1'b0, 1'b1, acc);
    idle(4);
    check("err_directed", bus.o_err, 3'b111);
`else
    check("err_directed", bus.o_err, 3'b011);
`endif

    // Reset while a done notification is stalled discards it.
    drive(1'b1, 9, 9, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    drive(1'b1, 9, 9, 1'b1, 1'b0, 1'b0, 1'b1, acc);
    for (int i = 0; i < 3; i++) drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("mid_rst_o_done_v", bus.o_done_v, 1'b0);
    check("mid_rst_o_err", bus.o_err, 0);
    check("mid_rst_o_we", bus.o_we, 1'b0);
    check("mid_rst_i_r", bus.i_r, 1'b0);
    wq.delete(); dq.delete(); err_at.delete();
    exp_err = 3'b000; m_err = 3'b000; m_pos = 0; m_bad = 1'b0; done_seen = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    idle(4);

    // Random traffic: mostly well-formed lines with occasional protocol faults.
    for (int i = 0; i < 400; i++) begin
      bit v, last, flush, flip, dr;
      int st, cl;
      v  = ($urandom_range(9) < 8);
      st = $urandom_range(l1_nstrms - 1);
      cl = $urandom_range(l1_ncl - 1);
      if (m_pos > 0 && $urandom_range(19) != 0) begin
        st = m_st; cl = m_cl;
      end
      last  = (m_pos == BEATS - 1) ? ($urandom_range(15) != 0) : ($urandom_range(15) == 0);
      flush = ($urandom_range(31) == 0);
      flip  = ($urandom_range(15) == 0);
      dr    = ($urandom_range(3) != 0);
      drive(v, st, cl, last, flush, flip, dr, acc);
    end
    idle(8);

    check("write_queue_drained", wq.size(), 0);
    check("done_queue_drained", dq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
